// File: rtl/fma32_pkg.sv
// Shared constants and stage-register layouts for the FP32 FMA normalize/round back end.
package fma32_pkg;
    localparam int unsigned ACC_W        = 75;
    localparam int unsigned POINT_POS    = 46;
    localparam int unsigned EXP_W        = 10;
    localparam int unsigned FP32_BIAS    = 127;
    localparam int unsigned FP32_EXP_MAX = 255;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [6:0]       lzc;
        logic [10:0]      be;
        logic [ACC_W-1:0] mag;
    } s1_t;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        tiny;
        logic        ovf;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        g;
        logic        r;
        logic        s;
    } s2_t;

    // Rounded magnitude plus the facts the output stage needs to pick the final encoding.
    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        tiny;
        logic        ovf;
        logic        inexact;
        logic [30:0] bits;
    } s3_t;
endpackage

// File: rtl/fma32_norm_round_lzc75.sv
// 75-bit leading-zero counter; reports 75 for an all-zero input.
module lzc75 (
    input  logic [74:0] data,
    output logic [6:0]  count
);
    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = 7'd75;
        for (int i = 0; i < 75; i++) begin
            if (data[i]) count = 7'(74 - i);
        end
    end
endmodule

// File: rtl/fma32_norm_round.sv
// FP32 FMA back end: LZC/normalise, denormalise, round-to-nearest-even and IEEE pack,
// as a valid/ready pipeline of S1, S2, S3 registers followed by a held output register.
module fma32_norm_round
    import fma32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [ACC_W-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact
);
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    logic v1, v2, v3;
    logic ld1, ld2, ld3, ld_o;
    logic [6:0] lzc;

    logic [ACC_W-1:0]   nm, nm_dn;
    logic [2*ACC_W-1:0] wide;
    logic [10:0]        sh11;
    logic [6:0]         sh;
    logic               tiny;
    logic               round_up;
    logic [30:0]        sum;
    logic [31:0]        res_d;
    logic               ovf_d, unf_d, inx_d;

    lzc75 u_lzc (
        .data  (in_mag),
        .count (lzc)
    );

    assign ld_o     = !out_valid | out_ready;
    assign ld3      = !v3 | ld_o;
    assign ld2      = !v2 | ld3;
    assign ld1      = !v1 | ld2;
    assign in_ready = ld1;

    always_comb begin
        s1_d.sign = in_sign;
        s1_d.zero = (in_mag == '0);
        s1_d.lzc  = lzc;
        s1_d.mag  = in_mag;
        // be = in_exp + (74 - lzc - POINT_POS) + bias
        s1_d.be   = {in_exp[EXP_W-1], in_exp} + 11'(FP32_BIAS + ACC_W - 1 - POINT_POS)
                  - {4'b0, lzc};
    end

    always_comb begin
        nm    = s1_q.mag << s1_q.lzc;
        tiny  = $signed(s1_q.be) <= 11'sd0;
        sh11  = 11'd1 - s1_q.be;
        sh    = (sh11 > 11'(ACC_W)) ? 7'(ACC_W) : sh11[6:0];
        // Low half of the wide shift collects the bits lost to denormalisation.
        wide  = {nm, {ACC_W{1'b0}}} >> sh;
        nm_dn = tiny ? wide[2*ACC_W-1:ACC_W] : nm;

        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.tiny = tiny;
        s2_d.ovf  = !tiny && ($signed(s1_q.be) >= $signed(11'(FP32_EXP_MAX)));
        s2_d.exp  = tiny ? 8'd0 : s1_q.be[7:0];
        s2_d.frac = nm_dn[ACC_W-2:ACC_W-24];
        s2_d.g    = nm_dn[ACC_W-25];
        s2_d.r    = nm_dn[ACC_W-26];
        s2_d.s    = (|nm_dn[ACC_W-27:0]) | (tiny & (|wide[ACC_W-1:0]));
    end

    always_comb begin
        round_up     = s2_q.g & (s2_q.r | s2_q.s | s2_q.frac[0]);
        // A carry out of the fraction bumps the exponent, which is the right answer
        // for both subnormal->normal and normal->next binade.
        sum          = {s2_q.exp, s2_q.frac} + 31'(round_up);
        s3_d.sign    = s2_q.sign;
        s3_d.zero    = s2_q.zero;
        s3_d.tiny    = s2_q.tiny;
        s3_d.ovf     = s2_q.ovf | (sum[30:23] == 8'(FP32_EXP_MAX));
        s3_d.inexact = s2_q.g | s2_q.r | s2_q.s;
        s3_d.bits    = sum;
    end

    always_comb begin
        res_d = {s3_q.sign, s3_q.bits};
        ovf_d = 1'b0;
        unf_d = s3_q.tiny & s3_q.inexact;
        inx_d = s3_q.inexact;
        if (s3_q.zero) begin
            res_d = {s3_q.sign, 31'b0};
            unf_d = 1'b0;
            inx_d = 1'b0;
        end else if (s3_q.ovf) begin
            res_d = {s3_q.sign, 8'hFF, 23'b0};
            ovf_d = 1'b1;
            unf_d = 1'b0;
            inx_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            out_valid     <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld1 && in_valid) s1_q <= s1_d;
            if (ld2) v2 <= v1;
            if (ld2 && v1) s2_q <= s2_d;
            if (ld3) v3 <= v2;
            if (ld3 && v2) s3_q <= s3_d;
            if (ld_o) out_valid <= v3;
            if (ld_o && v3) begin
                out_result    <= res_d;
                out_overflow  <= ovf_d;
                out_underflow <= unf_d;
                out_inexact   <= inx_d;
            end
        end
    end
endmodule

// File: tb/tb_fma32_norm_round.sv
// Scoreboard bench for fma32_norm_round: directed FP32 vectors, latency, stalls and reset.
module tb_fma32_norm_round;
    import fma32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [74:0] in_mag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } exp_t;

    typedef struct {
        logic        sign;
        logic [9:0]  e;
        logic [74:0] mag;
        exp_t        x;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    fma32_norm_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mag        (in_mag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output transfers are decided at the negedge: out_valid/out_ready are stable until the edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t got, want;
            got = {out_result, out_overflow, out_underflow, out_inexact};
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output: got %h, required no output", got);
            end else begin
                want = sb.pop_front();
                if (got !== want)
                    $display("FAIL result: got res=%h ovf=%b unf=%b inx=%b, required res=%h ovf=%b unf=%b inx=%b",
                             got.res, got.ovf, got.unf, got.inx,
                             want.res, want.ovf, want.unf, want.inx);
                else n_pass++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic add_vec(input logic s, input int e, input logic [74:0] m,
                           input logic [31:0] r, input logic o, input logic u, input logic x);
        vec_t v;
        v.sign = s;
        v.e    = 10'(e);
        v.mag  = m;
        v.x    = {r, o, u, x};
        vecs.push_back(v);
    endtask

    task automatic build_vectors;
        logic [74:0] one46, ones25, ones24;
        one46  = 75'd1 << 46;
        ones25 = ((75'd1 << 25) - 75'd1) << 22;
        ones24 = ((75'd1 << 24) - 75'd1) << 23;
        add_vec(0,    0, one46,                              32'h3F800000, 0, 0, 0);
        add_vec(0,    0, one46 | (75'd1 << 22),              32'h3F800000, 0, 0, 1);
        add_vec(0,    0, one46 | (75'd1 << 23) | (75'd1 << 22), 32'h3F800002, 0, 0, 1);
        add_vec(0,  128, one46,                              32'h7F800000, 1, 0, 1);
        add_vec(0,  127, ones25,                             32'h7F800000, 1, 0, 1);
        add_vec(0, -127, one46,                              32'h00400000, 0, 0, 0);
        add_vec(0, -127, one46 | 75'd1,                      32'h00400000, 0, 1, 1);
        add_vec(1,    0, 75'd0,                              32'h80000000, 0, 0, 0);
        add_vec(0,    0, 75'd0,                              32'h00000000, 0, 0, 0);
        add_vec(0,    3, 75'd3 << 45,                        32'h41400000, 0, 0, 0);
        add_vec(1,    3, 75'd3 << 45,                        32'hC1400000, 0, 0, 0);
        add_vec(0,    0, 75'd1 << 47,                        32'h40000000, 0, 0, 0);
        add_vec(0,    0, ones25,                             32'h40000000, 0, 0, 1);
        add_vec(0, -149, one46,                              32'h00000001, 0, 0, 0);
        add_vec(0, -150, one46,                              32'h00000000, 0, 1, 1);
        add_vec(0, -127, ones25,                             32'h00800000, 0, 1, 1);
        add_vec(1,  200, one46,                              32'hFF800000, 1, 0, 1);
        add_vec(0,  127, ones24,                             32'h7F7FFFFF, 0, 0, 0);
        add_vec(0,    0, 75'd1 << 74,                        32'h4D800000, 0, 0, 0);
        add_vec(0, -252, 75'd1 << 74,                        32'h00000000, 0, 1, 1);
        add_vec(0,  254, 75'd1,                              32'h7F800000, 1, 0, 1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word transfers or the budget expires.
    task automatic send(input vec_t v, output bit ok);
        int waitc = 0;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.e;
        in_mag   = v.mag;
        while (!ok && waitc < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb.push_back(v.x);
            end
            @(posedge clk);
            #1;
            waitc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waitc = 0;
        while (sb.size() != 0 && waitc < 500) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: got %0d pending, required 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        else n_pass++;
        n_checks++;
        if ({out_result, out_overflow, out_underflow, out_inexact} !== 35'd0)
            $display("FAIL reset_outputs: got %h, required 0",
                     {out_result, out_overflow, out_underflow, out_inexact});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_latency;
        int lat = 0;
        bit ok;
        out_ready = 1'b1;
        send(vecs[0], ok);
        n_checks++;
        if (!ok) $display("FAIL latency_accept: got stalled, required accepted");
        else n_pass++;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat != 3) $display("FAIL latency: got %0d cycles, required 3", lat);
        else n_pass++;
        drain("latency");
    endtask

    task automatic test_directed;
        int rejected = 0;
        bit ok;
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i], ok);
            if (!ok) rejected++;
        end
        n_checks++;
        if (rejected != 0) $display("FAIL directed_accept: got %0d rejected, required 0", rejected);
        else n_pass++;
        drain("directed");
    endtask

    task automatic test_back_to_back;
        int start;
        bit ok;
        out_ready = 1'b1;
        start = cyc;
        foreach (vecs[i]) send(vecs[i], ok);
        n_checks++;
        if (cyc - start != vecs.size())
            $display("FAIL back_to_back_cycles: got %0d, required %0d", cyc - start, vecs.size());
        else n_pass++;
        drain("back_to_back");
    endtask

    task automatic test_backpressure;
        int acc = 0;
        logic [5:0] pat = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sign  = vecs[i].sign;
            in_exp   = vecs[i].e;
            in_mag   = vecs[i].mag;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                sb.push_back(vecs[i].x);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc != 4) $display("FAIL bp_accepted: got %0d, required 4", acc);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", in_ready);
        else n_pass++;
        repeat (2) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== vecs[0].x.res)
                $display("FAIL bp_hold: got valid=%b res=%h, required valid=1 res=%h",
                         out_valid, out_result, vecs[0].x.res);
            else n_pass++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = out_valid;
        end
        n_checks++;
        if (pat !== 6'b001111) $display("FAIL bp_release: got %b, required 001111", pat);
        else n_pass++;
        @(posedge clk);
        #1;
        drain("backpressure");
    endtask

    task automatic test_random_stall;
        bit done = 1'b0;
        int rejected = 0;
        fork
            begin
                bit ok;
                foreach (vecs[i]) begin
                    send(vecs[i], ok);
                    if (!ok) rejected++;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        n_checks++;
        if (rejected != 0) $display("FAIL stall_accept: got %0d rejected, required 0", rejected);
        else n_pass++;
        drain("random_stall");
    endtask

    task automatic test_reset_midstream;
        bit ok;
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[i + 9], ok);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL mid_busy: got out_valid=%b, required 1", out_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_result !== 32'd0)
            $display("FAIL mid_reset: got valid=%b res=%h, required valid=0 res=00000000",
                     out_valid, out_result);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b, required 1", in_ready);
        else n_pass++;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL mid_flushed: got %0d outputs, required 0", seen);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        build_vectors();
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fma32_norm_round.md
Name: fma32_norm_round

Overview:
Downstream stage of the FP32 fused multiply-add datapath. It consumes the raw signed-magnitude sum from the FMA alignment adder (a 75-bit magnitude, result sign, and unbiased product exponent) and performs leading-zero detection, normalization, subnormal denormalization, round-to-nearest-even, overflow/underflow handling and IEEE-754 packing. It is a 3-stage valid/ready pipeline, so the combinational FMA core can be registered behind it without losing throughput.

Parameters:
ACC_W, 75, width of incoming magnitude
POINT_POS, 46, bit index of in_mag carrying weight 2^in_exp (binary point of the 1.23 x 1.23 product)
EXP_W, 10, width of signed unbiased input exponent

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word present
in_ready  output  1  stage can accept this cycle
in_sign  input  1  sign of result (upstream gives 0 on exact cancellation)
in_exp  input  EXP_W  signed unbiased exponent (true_a+true_b, range -252..254)
in_mag  input  ACC_W  magnitude; value = (-1)^in_sign * in_mag * 2^(in_exp-POINT_POS)
out_valid  output  1  result present
out_ready  input  1  downstream accepts
out_result  output  32  packed IEEE-754 single
out_overflow  output  1  result rounded to infinity
out_underflow  output  1  tiny before rounding and inexact
out_inexact  output  1  any of guard/round/sticky nonzero

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, out_valid, out_result and the three flags go to 0 immediately. in_ready is 1 after reset. Words in flight are discarded. No partial output.
- Handshake: a transfer happens when valid&ready. Stage k loads when it is empty or stage k+1 loads. The output stage loads when it is empty or out_ready=1. in_ready = !v1 | (stage 1 advances). Bubbles collapse. Order is preserved. Outputs stay stable while out_valid&!out_ready.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 word/cycle.
- S1: lzc = leading zeros of in_mag (0..75). p = 74-lzc. Biased exponent be = in_exp + (p-POINT_POS) + 127, computed in 11-bit signed. Register zero = (in_mag==0).
- S2:
  - Normalize: nm = in_mag << lzc, so the leading 1 sits at bit 74.
  - If be <= 0: shift nm right by min(1-be, 75); shifted-out bits OR into sticky; exponent field = 0.
  - If be >= 255: force overflow.
  - Otherwise exponent field = be[7:0].
  - frac = nm[73:51], guard = nm[50], round = nm[49], sticky = |nm[48:0] | shifted-out bits.
- S3:
  - round_up = guard & (round | sticky | frac[0]).
  - {exp,frac} as a 31-bit integer + round_up. A carry from frac into exp is correct for both the subnormal->normal and normal->next-binade cases.
  - If the result exp field is 255, or overflow was forced in S2: out_result = {sign,8'hFF,23'b0}, out_overflow=1.
  - If zero: out_result = {in_sign,31'b0} and all flags 0.
  - out_inexact = guard|round|sticky, or 1 when overflowing.
  - out_underflow = (be <= 0) & out_inexact.
- NaN/Inf operands are not handled here. Special-case bypass belongs to the operand-classification stage.

Decomposition:
- Package fma32_pkg holds:
  - Constants FP32_BIAS=127, FP32_EXP_MAX=255, ACC_W, POINT_POS.
  - Typedefs for the packed stage registers: s1_t {sign, zero, lzc[6:0], be[10:0], mag}; s2_t {sign, zero, tiny, ovf, exp[7:0], frac[22:0], g, r, s}.
- One combinational sub-module, lzc75: 75-bit leading-zero counter with a 7-bit count output, and 75 when the input is zero.

Test Plan:
- in_mag=1<<46, in_exp=0, sign=0 -> 3 cycles later out_result=0x3F800000, no flags.
- in_mag=(1<<46)|(1<<22), exp=0 (exact tie, even LSB) -> 0x3F800000, inexact=1. in_mag=(1<<46)|(1<<23)|(1<<22) -> 0x3F800002, inexact=1.
- in_mag=1<<46, exp=128 -> 0x7F800000, overflow=1, inexact=1. in_mag=all-ones bits[46:22], exp=127 -> rounds to 0x7F800000, overflow=1.
- in_mag=1<<46, exp=-127 -> 0x00400000, underflow=0 (exact). in_mag=(1<<46)|1, exp=-127 -> 0x00400000, underflow=1, inexact=1.
- in_mag=0, in_sign=1 -> 0x80000000, all flags 0. in_mag=0, in_sign=0 -> 0x00000000.
- Backpressure: hold out_ready=0 while offering 5 consecutive words -> exactly 4 accepted (3 stages plus the held output), then in_ready=0. Release out_ready -> results emerge in order, one per cycle. Assert rst_n mid-stream -> out_valid=0 immediately and nothing is emitted afterwards.
